// File: rtl/if_id_stage_if.sv
// Signal bundle between the fetch stage and its neighbours: hazard/branch control in,
// instruction-memory and IF/ID register contents out.
interface if_id_stage_if;
  logic        start_i;
  logic        PCWrite_i;
  logic        Stall_i;
  logic        Flush_i;
  logic        Branch_i;
  logic [31:0] BranchTarget_i;
  logic [31:0] IF_instr_i;
  logic [31:0] IF_pc_o;
  logic [31:0] ID_pc_o;
  logic [31:0] ID_instr_o;
  logic        ID_valid_o;

  modport master (
    output start_i, PCWrite_i, Stall_i, Flush_i, Branch_i, BranchTarget_i, IF_instr_i,
    input  IF_pc_o, ID_pc_o, ID_instr_o, ID_valid_o
  );

  modport slave (
    input  start_i, PCWrite_i, Stall_i, Flush_i, Branch_i, BranchTarget_i, IF_instr_i,
    output IF_pc_o, ID_pc_o, ID_instr_o, ID_valid_o
  );
endinterface

// File: rtl/if_id_stage.sv
// Instruction fetch with program counter and IF/ID pipeline register for a five-stage
// RISC-V pipeline. All outputs are registered.
module if_id_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input logic           clk_i,
  input logic           rst_i,
  if_id_stage_if.slave  bus
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_instr_q, id_instr_d;
  logic        id_valid_q, id_valid_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      pc_q       <= RESET_PC;
      id_pc_q    <= '0;
      id_instr_q <= NOP_INSTR;
      id_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      id_pc_q    <= id_pc_d;
      id_instr_q <= id_instr_d;
      id_valid_q <= id_valid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    id_pc_d    = id_pc_q;
    id_instr_d = id_instr_q;
    id_valid_d = id_valid_q;
    unique case (state_q)
      StIdle: begin
        // Hazard and branch inputs are meaningless before fetch starts.
        pc_d       = RESET_PC;
        id_pc_d    = '0;
        id_instr_d = NOP_INSTR;
        id_valid_d = 1'b0;
        if (bus.start_i) begin
          state_d    = StRun;
          pc_d       = pc_q + 32'd4;
          id_pc_d    = pc_q;
          id_instr_d = bus.IF_instr_i;
          id_valid_d = 1'b1;
        end
      end
      StRun: begin
        if (!bus.PCWrite_i) begin
          pc_d = pc_q;
        end else if (bus.Branch_i) begin
          pc_d = bus.BranchTarget_i;
        end else begin
          pc_d = pc_q + 32'd4;
        end
        // Stall wins over flush: a stalled branch has not resolved yet.
        if (bus.Stall_i) begin
          id_pc_d    = id_pc_q;
          id_instr_d = id_instr_q;
          id_valid_d = id_valid_q;
        end else if (bus.Flush_i) begin
          id_pc_d    = '0;
          id_instr_d = NOP_INSTR;
          id_valid_d = 1'b0;
        end else begin
          id_pc_d    = pc_q;
          id_instr_d = bus.IF_instr_i;
          id_valid_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign bus.IF_pc_o    = pc_q;
  assign bus.ID_pc_o    = id_pc_q;
  assign bus.ID_instr_o = id_instr_q;
  assign bus.ID_valid_o = id_valid_q;

endmodule

// File: tb/tb_if_id_stage.sv
// Directed walk through the fetch stage's scenarios, then randomized hazard/branch traffic
// compared against a behavioural pipeline model every cycle.
module tb_if_id_stage;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  if_id_stage_if bus ();

  if_id_stage #(
    .RESET_PC  (RESET_PC),
    .NOP_INSTR (NOP_INSTR)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Synthetic instruction memory; word 0 is addi x1,x0,5.
  function automatic logic [31:0] imem_f(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  assign bus.IF_instr_i = imem_f(bus.IF_pc_o);

  // Reference model state.
  bit          m_run;
  logic [31:0] m_pc, m_id_pc, m_id_instr;
  logic        m_id_valid;

  task automatic model_reset();
    m_run = 0; m_pc = RESET_PC; m_id_pc = 0; m_id_instr = NOP_INSTR; m_id_valid = 0;
  endtask

  task automatic model_bubble();
    m_id_pc = 0; m_id_instr = NOP_INSTR; m_id_valid = 0;
  endtask

  task automatic model_edge(input bit start, pcw, stall, flush, br, input logic [31:0] tgt);
    logic [31:0] next_pc;
    if (!m_run) begin
      if (start) begin
        m_run = 1; m_id_pc = m_pc; m_id_instr = imem_f(m_pc); m_id_valid = 1; m_pc = m_pc + 4;
      end else begin
        m_pc = RESET_PC; model_bubble();
      end
    end else begin
      next_pc = !pcw ? m_pc : (br ? tgt : m_pc + 4);
      if (!stall) begin
        if (flush) model_bubble();
        else begin m_id_pc = m_pc; m_id_instr = imem_f(m_pc); m_id_valid = 1; end
      end
      m_pc = next_pc;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".IF_pc"},    bus.IF_pc_o,           m_pc);
    chk({tag, ".ID_pc"},    bus.ID_pc_o,           m_id_pc);
    chk({tag, ".ID_instr"}, bus.ID_instr_o,        m_id_instr);
    chk({tag, ".ID_valid"}, {31'b0, bus.ID_valid_o}, {31'b0, m_id_valid});
  endtask

  // Drive one cycle of inputs, take the edge, then compare 1 time unit later.
  task automatic cycle(input string tag, input bit start, pcw, stall, flush, br,
                       input logic [31:0] tgt);
    bus.start_i = start; bus.PCWrite_i = pcw; bus.Stall_i = stall;
    bus.Flush_i = flush; bus.Branch_i = br; bus.BranchTarget_i = tgt;
    @(posedge clk);
    model_edge(start, pcw, stall, flush, br, tgt);
    #1;
    chk_model(tag);
  endtask

  task automatic run(input string tag);
    cycle(tag, 1, 1, 0, 0, 0, 32'h0);
  endtask

  initial begin
    rst = 1'b1;
    bus.start_i = 0; bus.PCWrite_i = 1; bus.Stall_i = 0; bus.Flush_i = 0;
    bus.Branch_i = 0; bus.BranchTarget_i = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk_model("reset");
    chk("reset.ID_instr_const", bus.ID_instr_o, 32'h13);
    rst = 1'b0;

    // Idle: inputs other than start must be ignored.
    cycle("idle0", 0, 0, 1, 1, 1, 32'h100);
    chk("idle0.pc_const", bus.IF_pc_o, 32'h0);
    cycle("start", 1, 1, 0, 0, 0, 32'h0);
    chk("start.pc", bus.IF_pc_o, 32'h4);
    chk("start.instr", bus.ID_instr_o, 32'h0050_0093);
    chk("start.idpc", bus.ID_pc_o, 32'h0);
    chk("start.valid", {31'b0, bus.ID_valid_o}, 32'h1);
    run("run8");
    chk("run8.pc", bus.IF_pc_o, 32'h8);

    cycle("loaduse", 0, 0, 1, 0, 0, 32'h0);
    chk("loaduse.pc", bus.IF_pc_o, 32'h8);
    chk("loaduse.idpc", bus.ID_pc_o, 32'h4);
    run("resume");
    chk("resume.pc", bus.IF_pc_o, 32'hC);
    chk("resume.idpc", bus.ID_pc_o, 32'h8);
    run("run16");

    cycle("branch", 0, 1, 0, 1, 1, 32'h40);
    chk("branch.pc", bus.IF_pc_o, 32'h40);
    chk("branch.instr", bus.ID_instr_o, 32'h13);
    chk("branch.valid", {31'b0, bus.ID_valid_o}, 32'h0);
    run("target");
    chk("target.idpc", bus.ID_pc_o, 32'h40);
    chk("target.valid", {31'b0, bus.ID_valid_o}, 32'h1);

    cycle("stallbr", 0, 0, 1, 1, 1, 32'h80);
    chk("stallbr.pc", bus.IF_pc_o, 32'h44);
    chk("stallbr.idpc", bus.ID_pc_o, 32'h40);
    cycle("stallbr_go", 0, 1, 0, 1, 1, 32'h80);
    chk("stallbr_go.pc", bus.IF_pc_o, 32'h80);

    cycle("refetch", 0, 0, 0, 0, 0, 32'h0);
    chk("refetch.idpc", bus.ID_pc_o, 32'h80);
    cycle("br_noflush", 0, 1, 0, 0, 1, 32'h200);
    chk("br_noflush.valid", {31'b0, bus.ID_valid_o}, 32'h1);

    cycle("to_top", 0, 1, 0, 1, 1, 32'hFFFF_FFFC);
    run("wrap");
    chk("wrap.pc", bus.IF_pc_o, 32'h0);
    chk("wrap.idpc", bus.ID_pc_o, 32'hFFFF_FFFC);

    cycle("to_20", 0, 1, 0, 1, 1, 32'h20);
    run("at_24");
    chk("at_24.pc", bus.IF_pc_o, 32'h24);
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk_model("async_rst");
    chk("async_rst.pc", bus.IF_pc_o, RESET_PC);
    #2 rst = 1'b0;
    cycle("frozen0", 0, 1, 0, 0, 0, 32'h0);
    cycle("frozen1", 0, 1, 0, 0, 1, 32'h300);
    chk("frozen1.pc", bus.IF_pc_o, RESET_PC);
    cycle("restart", 1, 1, 0, 0, 0, 32'h0);
    chk("restart.pc", bus.IF_pc_o, 32'h4);

    // Randomized traffic with occasional asynchronous resets.
    for (int i = 0; i < 400; i++) begin
      bit s, pw, st, fl, b;
      logic [31:0] t;
      s  = ($urandom_range(0, 3) == 0);
      pw = ($urandom_range(0, 4) != 0);
      st = ($urandom_range(0, 4) == 0);
      b  = ($urandom_range(0, 5) == 0);
      fl = b ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 9) == 0);
      t  = ($urandom_range(0, 7) == 0) ? $urandom : {$urandom_range(0, 1023), 2'b00};
      cycle("rand", s, pw, st, fl, b, t);
      if ($urandom_range(0, 60) == 0) begin
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk_model("rand_rst");
        @(posedge clk);
        #1 rst = 1'b0;
        chk_model("rand_rst_hold");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_id_stage.md
# if_id_stage

Instruction-fetch stage plus IF/ID pipeline register for the five-stage RISC-V pipeline. Owns the program counter, drives the instruction-memory address, and latches the fetched instruction and its PC for the decode stage. It sits directly upstream of load-use hazard detection and consumes that logic's PC-write and stall decisions. It also takes the branch redirect and flush from ID.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000: PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013: encoding inserted as a bubble (addi x0,x0,0).

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  reset, asynchronous, active-high.
- start_i  input  1  level; enables fetch once sampled high.
- PCWrite_i  input  1  1 = PC may update; 0 = freeze PC (load-use stall).
- Stall_i  input  1  1 = hold IF/ID register contents.
- Flush_i  input  1  1 = replace the IF/ID contents with a bubble (taken branch resolved in ID).
- Branch_i  input  1  1 = redirect PC to BranchTarget_i.
- BranchTarget_i  input  32  redirect address computed in ID.
- IF_instr_i  input  32  instruction-memory read data for the address on IF_pc_o, combinational, same cycle.
- IF_pc_o  output  32  current PC; instruction-memory address.
- ID_pc_o  output  32  PC of the instruction held in IF/ID.
- ID_instr_o  output  32  instruction held in IF/ID.
- ID_valid_o  output  1  1 = ID_instr_o is a real fetched instruction; 0 = bubble.

## Operation
- Two-state control FSM: IDLE, RUN.
  - Reset forces IDLE.
  - IDLE -> RUN on the first rising edge with start_i=1.
  - RUN is held until reset; start_i is ignored once in RUN.
- In IDLE:
  - PC holds RESET_PC.
  - IF/ID is loaded with a bubble every cycle.
  - All hazard and branch inputs are ignored.
- PC update in RUN, in priority order:
  1. PCWrite_i=0: PC holds; Branch_i is ignored.
  2. Branch_i=1: PC <= BranchTarget_i.
  3. Otherwise: PC <= PC + 4, modulo 2^32. 32'hFFFF_FFFC wraps to 0.
- IF/ID update in RUN, in priority order:
  1. Stall_i=1: all IF/ID fields hold. Stall outranks Flush_i, because a branch whose operands are stalled is not yet resolved.
  2. Flush_i=1: ID_instr_o <= NOP_INSTR, ID_pc_o <= 0, ID_valid_o <= 0.
  3. Otherwise: ID_instr_o <= IF_instr_i, ID_pc_o <= PC, ID_valid_o <= 1.
- PCWrite_i=0 with Stall_i=0 is legal. The PC holds while IF/ID reloads the same instruction, re-fetching it with the same PC.
- Branch_i=1 without Flush_i is legal: the PC redirects and IF/ID latches the fall-through instruction. Upstream normally asserts both together.
- BranchTarget_i is used unmodified; no alignment check is performed.
- No output depends combinationally on any input. IF_pc_o is the PC register.

## Timing
- Reset values, applied asynchronously while rst_i=1:
  - IF_pc_o = RESET_PC
  - ID_pc_o = 0
  - ID_instr_o = NOP_INSTR
  - ID_valid_o = 0
  - FSM = IDLE
- Reset deassertion is taken synchronously. The first PC advance is on the edge where start_i is sampled high in IDLE:
  - IF/ID receives the instruction at RESET_PC on that same edge.
  - PC becomes RESET_PC+4 on that same edge.
- Fetch-to-decode latency: 1 cycle. The instruction at IF_pc_o in cycle n appears on ID_instr_o in cycle n+1.
- Stall: each cycle with PCWrite_i=0 and Stall_i=1 holds both PC and IF/ID for exactly one cycle. Fetch resumes on the first edge with both released.
- Taken branch (Branch_i=1, Flush_i=1, PCWrite_i=1): the cycle after the edge, IF_pc_o = target and ID_valid_o = 0 (one bubble). The target instruction reaches ID one cycle later.
- Reset mid-operation: all outputs return to their reset values immediately, without waiting for a clock edge. start_i must then be sampled again.

## Test plan
- Reset/start: hold rst_i 3 cycles, then start_i=1 at cycle 5 with imem[0]=32'h00500093 → IF_pc_o 0,0,…,4,8; ID_instr_o=32'h00500093, ID_pc_o=0, ID_valid_o=1 one cycle after start is sampled.
- Load-use stall: at PC=8, pulse PCWrite_i=0 and Stall_i=1 for one cycle → IF_pc_o stays 8 and ID_pc_o stays 4 for that cycle; next cycle IF_pc_o=12, ID_pc_o=8.
- Taken branch: at PC=16 assert Branch_i=1, Flush_i=1, BranchTarget_i=32'h40 → next cycle IF_pc_o=32'h40, ID_instr_o=32'h13, ID_valid_o=0; following cycle ID_pc_o=32'h40, ID_valid_o=1.
- Stall with simultaneous branch/flush: Stall_i=1, PCWrite_i=0, Branch_i=1, Flush_i=1 → PC and IF/ID unchanged; the branch is honoured the next cycle once the stall drops.
- Wrap-around: force the PC to 32'hFFFF_FFFC via a branch → next IF_pc_o=0.
- Async reset mid-run: assert rst_i between edges at PC=32'h24 → IF_pc_o=RESET_PC and ID_valid_o=0 before the next edge; fetch stays frozen until start_i is sampled high again.
